logic_unit_arbiter: RTL and testbench

//  Shares one bitwise logic unit between two requesters. The unit computes

---
 rtl/logic_unit_arbiter.sv | 151 +++++++++++++++
 tb/tb_logic_unit_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// logic_unit_arbiter
//
// Shares one bitwise logic unit between two requesters. The unit computes
// ~a & b (op=0) or a | b (op=1). Requesters are served round-robin. The
// winner's operands are captured, one compute cycle runs, and the result is
// then held behind a valid/ready handshake until the consumer takes it.
//
// Parameters
//   WIDTH        operand/result width in bits
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous reset, active low
//   req0_valid   requester 0 has an operation pending
//   req0_op      requester 0 op: 0 = ~a&b, 1 = a|b
//   req0_a/b     requester 0 operands
//   req0_ready   requester 0 accepted this cycle (combinational)
//   req1_*       same set for requester 1
//   res_valid    result available
//   res_ready    consumer takes the result
//   res_id       requester that owns the result
//   res_op       op that produced the result
//   res_data     result
//   busy         high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module logic_unit_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic             res_op,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic             res_op_q, res_op_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;

  // Round-robin: a lone requester always wins; on contention the requester
  // that was not granted last time wins.
  logic win0, win1;
  assign win0 = req0_valid && (!req1_valid || last_grant_q);
  assign win1 = req1_valid && (!req0_valid || !last_grant_q);

  // Ready is gated by rst_n so it is forced low while reset is asserted,
  // even though the state register already reads IDLE.
  assign req0_ready = rst_n && (state_q == IDLE) && win0;
  assign req1_ready = rst_n && (state_q == IDLE) && win1;

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_op    = res_op_q;
  assign res_data  = res_data_q;
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_op_d     = res_op_q;
    res_data_d   = res_data_q;
    case (state_q)
      IDLE: begin
        if (win0 || win1) begin
          // win1 doubles as the id of the accepted requester
          op_d         = win1 ? req1_op : req0_op;
          a_d          = win1 ? req1_a  : req0_a;
          b_d          = win1 ? req1_b  : req0_b;
          id_d         = win1;
          last_grant_d = win1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = op_q ? (a_q | b_q) : (~a_q & b_q);
        res_id_d    = id_q;
        res_op_d    = op_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // res_data is left untouched so it keeps its last value after the handshake
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_op_q     <= 1'b0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_op_q     <= res_op_d;
      res_data_q   <= res_data_d;
    end
  end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// -----------------------------------------------------------------------------
// tb_logic_unit_arbiter
//
// Directed bench for logic_unit_arbiter: a WIDTH=4 instance for the
// arbitration, handshake and reset scenarios, and a WIDTH=1 instance for the
// exhaustive truth table of both ops.
// -----------------------------------------------------------------------------
module tb_logic_unit_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_op, req0_ready;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_op, req1_ready;
  logic [3:0] req1_a, req1_b;
  logic       res_valid, res_ready, res_id, res_op, busy;
  logic [3:0] res_data;

  logic       w_req0_valid, w_req0_op, w_req0_ready;
  logic [0:0] w_req0_a, w_req0_b;
  logic       w_req1_valid, w_req1_op, w_req1_ready;
  logic [0:0] w_req1_a, w_req1_b;
  logic       w_res_valid, w_res_ready, w_res_id, w_res_op, w_busy;
  logic [0:0] w_res_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic_unit_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id), .res_op(res_op),
    .res_data(res_data), .busy(busy)
  );

  logic_unit_arbiter #(.WIDTH(1)) dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(w_req0_valid), .req0_op(w_req0_op), .req0_a(w_req0_a), .req0_b(w_req0_b),
    .req0_ready(w_req0_ready),
    .req1_valid(w_req1_valid), .req1_op(w_req1_op), .req1_a(w_req1_a), .req1_b(w_req1_b),
    .req1_ready(w_req1_ready),
    .res_valid(w_res_valid), .res_ready(w_res_ready), .res_id(w_res_id), .res_op(w_res_op),
    .res_data(w_res_data), .busy(w_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single request from one requester with res_ready high; checks ready
  // timing, latency, result fields and return to idle. Operands are
  // scrambled right after the accept edge to show they were captured.
  task automatic run_single(input string tag, input logic id, input logic op,
                            input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] exp);
    int wait_cycles;
    logic seen;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end
    #1;
    seen = 1'b0;
    wait_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        seen = 1'b1;
        break;
      end
      wait_cycles++;
      @(negedge clk); #1;
    end
    check({tag, "_ready_seen"}, 8'(seen), 8'd1);
    check({tag, "_ready_same_cycle"}, 8'(wait_cycles), 8'd0);
    check({tag, "_other_ready"}, 8'(id ? req0_ready : req1_ready), 8'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a; req0_b = ~b; req1_a = ~a; req1_b = ~b;
    req0_op = ~op; req1_op = ~op;
    check({tag, "_exec_busy"}, 8'(busy), 8'd1);
    check({tag, "_exec_valid"}, 8'(res_valid), 8'd0);
    @(posedge clk); #1;
    check({tag, "_res_valid"}, 8'(res_valid), 8'd1);
    check({tag, "_res_data"}, 8'(res_data), 8'(exp));
    check({tag, "_res_id"}, 8'(res_id), 8'(id));
    check({tag, "_res_op"}, 8'(res_op), 8'(op));
    $display("txn %s: id=%0d op=%0d a=%b b=%b -> data=%b", tag, id, op, a, b, res_data);
    @(posedge clk); #1;
    check({tag, "_idle_valid"}, 8'(res_valid), 8'd0);
    check({tag, "_idle_busy"}, 8'(busy), 8'd0);
  endtask

  logic [3:0] tt_op0;
  logic [3:0] tt_op1;
  logic [3:0] exp_data;
  logic       exp_id;

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_op = 1'b0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 1'b0; req1_a = '0; req1_b = '0;
    res_ready = 1'b1;
    w_req0_valid = 1'b0; w_req0_op = 1'b0; w_req0_a = '0; w_req0_b = '0;
    w_req1_valid = 1'b0; w_req1_op = 1'b0; w_req1_a = '0; w_req1_b = '0;
    w_res_ready = 1'b1;

    // Reset state, with a request pending to show ready is forced low
    @(posedge clk); #1;
    req0_valid = 1'b1;
    #1;
    check("rst_req0_ready", 8'(req0_ready), 8'd0);
    check("rst_res_valid", 8'(res_valid), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_res_data", 8'(res_data), 8'd0);
    check("rst_res_id", 8'(res_id), 8'd0);
    check("rst_res_op", 8'(res_op), 8'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single transactions: ~a&b and a|b
    run_single("t1_req0_andn", 1'b0, 1'b0, 4'b0011, 4'b0101, 4'b0100);
    run_single("t2_req1_or",   1'b1, 1'b1, 4'b0011, 4'b0101, 4'b0111);

    // Both requesting continuously from reset: alternation starting with req0,
    // one accept every 3 cycles
    @(negedge clk);
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = 1'b0; req0_a = 4'b0011; req0_b = 4'b0101;
    req1_valid = 1'b1; req1_op = 1'b1; req1_a = 4'b0011; req1_b = 4'b0101;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id = 1'(k % 2);
      exp_data = exp_id ? 4'b0111 : 4'b0100;
      #1;
      check($sformatf("t3_k%0d_ready0", k), 8'(req0_ready), 8'(!exp_id));
      check($sformatf("t3_k%0d_ready1", k), 8'(req1_ready), 8'(exp_id));
      @(negedge clk);
      check($sformatf("t3_k%0d_exec_readys", k), 8'({req0_ready, req1_ready}), 8'd0);
      @(negedge clk);
      check($sformatf("t3_k%0d_resp_readys", k), 8'({req0_ready, req1_ready}), 8'd0);
      check($sformatf("t3_k%0d_res_valid", k), 8'(res_valid), 8'd1);
      check($sformatf("t3_k%0d_res_id", k), 8'(res_id), 8'(exp_id));
      check($sformatf("t3_k%0d_res_data", k), 8'(res_data), 8'(exp_data));
      $display("txn t3_k%0d: id=%0d data=%b", k, res_id, res_data);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Consumer stalls for 5 cycles in RESP
    res_ready = 1'b0;
    @(negedge clk);
    req1_valid = 1'b1; req1_op = 1'b0; req1_a = 4'b1010; req1_b = 4'b0110;
    #1;
    check("t4_ready1", 8'(req1_ready), 8'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 1'b1; req0_a = 4'b1111; req0_b = 4'b0000;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("t4_c%0d_res_valid", c), 8'(res_valid), 8'd1);
      check($sformatf("t4_c%0d_res_data", c), 8'(res_data), 8'b0100);
      check($sformatf("t4_c%0d_readys", c), 8'({req0_ready, req1_ready}), 8'd0);
      check($sformatf("t4_c%0d_busy", c), 8'(busy), 8'd1);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("t4_release_busy", 8'(busy), 8'd0);
    check("t4_release_valid", 8'(res_valid), 8'd0);
    check("t4_release_data_kept", 8'(res_data), 8'b0100);
    check("t4_release_ready0", 8'(req0_ready), 8'd1);
    req0_valid = 1'b0;
    $display("txn t4: stalled result %b released", res_data);

    // Reset during EXEC after granting req0; req0 must still win first after release
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 1'b1; req0_a = 4'b0001; req0_b = 4'b0010;
    #1;
    check("t5_ready0", 8'(req0_ready), 8'd1);
    @(posedge clk); #1;
    check("t5_exec_busy", 8'(busy), 8'd1);
    req1_valid = 1'b1; req1_op = 1'b0; req1_a = 4'b0000; req1_b = 4'b1111;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 8'(busy), 8'd0);
    check("t5_rst_valid", 8'(res_valid), 8'd0);
    check("t5_rst_readys", 8'({req0_ready, req1_ready}), 8'd0);
    @(posedge clk); #1;
    check("t5_rst_hold_valid", 8'(res_valid), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t5_after_ready0", 8'(req0_ready), 8'd1);
    check("t5_after_ready1", 8'(req1_ready), 8'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    check("t5_res_id", 8'(res_id), 8'd0);
    check("t5_res_data", 8'(res_data), 8'b0011);
    $display("txn t5: after reset id=%0d data=%b", res_id, res_data);
    @(posedge clk); #1;

    // WIDTH=1 truth table; index by {a,b}
    tt_op0 = 4'b0010;
    tt_op1 = 4'b1110;
    for (int op = 0; op < 2; op++) begin
      for (int ab = 0; ab < 4; ab++) begin
        @(negedge clk);
        w_req0_valid = 1'b1;
        w_req0_op = 1'(op);
        w_req0_a = 1'(ab >> 1);
        w_req0_b = 1'(ab);
        #1;
        check($sformatf("t6_op%0d_ab%0d_ready", op, ab), 8'(w_req0_ready), 8'd1);
        @(posedge clk); #1;
        w_req0_valid = 1'b0;
        @(posedge clk); #1;
        check($sformatf("t6_op%0d_ab%0d_valid", op, ab), 8'(w_res_valid), 8'd1);
        check($sformatf("t6_op%0d_ab%0d_data", op, ab), 8'(w_res_data),
              8'(op ? tt_op1[ab] : tt_op0[ab]));
        $display("txn t6: op=%0d a=%0d b=%0d -> %0d", op, ab >> 1, ab & 1, w_res_data);
        @(posedge clk); #1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
